// File: rtl/load_store_unit.sv
// Memory-access stage: one req/ack data-memory transaction per start, lane-aligned stores, extended loads.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses complete with err instead of being force-aligned.
module load_store_unit #(
    parameter int width   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] addr,
    input  logic [width-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [width-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [width-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [width-1:0] mem_rdata,
    output logic [1:0]       dbg_state
);
    // Handshake: mem_req rises on entry to REQ with all mem_* fields stable, and stays high
    // until the cycle mem_ack is sampled high (or the timeout fires); mem_ack elsewhere is ignored.
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic             st_q;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic             illegal, bad;
    logic [1:0]       off;
    logic [3:0]       be;
    logic             fire_req, fire_err, ack_ok, tmo;
    logic [width-1:0] lane, ext;

    always_comb begin
        illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110) || (is_store && funct3[2]);
`ifdef MISALIGN_TRAP_EN
        bad = illegal || (funct3[1:0] == 2'b01 && addr[0])
                      || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
        bad = illegal;
`endif
        // Without the trap, misaligned low bits are simply dropped for H and W.
        off = 2'b00;
        be  = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                off = addr[1:0];
                be  = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                off = {addr[1], 1'b0};
                be  = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        fire_req = 1'b0;
        fire_err = 1'b0;
        ack_ok   = 1'b0;
        tmo      = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                if (bad) begin
                    fire_err = 1'b1;
                    state_d  = DONE;
                end else begin
                    fire_req = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: if (mem_ack) begin
                ack_ok  = 1'b1;
                state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                tmo     = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        lane = mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{(width - 8){lane[7]}}, lane[7:0]};
            3'b100:  ext = {{(width - 8){1'b0}}, lane[7:0]};
            3'b001:  ext = {{(width - 16){lane[15]}}, lane[15:0]};
            3'b101:  ext = {{(width - 16){1'b0}}, lane[15:0]};
            default: ext = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            st_q      <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            err <= fire_err || tmo;
            if (fire_req) begin
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {addr[width-1:2], 2'b00};
                mem_be    <= be;
                mem_wdata <= wdata << {off, 3'b000};
                st_q      <= is_store;
                f3_q      <= funct3;
                off_q     <= off;
            end else if (ack_ok || tmo) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
            if (ack_ok && !st_q) rdata <= ext;
            if (state_q == REQ && !mem_ack) cnt_q <= cnt_q + CW'(1);
            else                            cnt_q <= '0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;
endmodule
